c1_responder: RTL and testbench

C1_RESPONDER -- requirements
Module: c1_responder

---
 rtl/c1_pkg.sv | 50 +++++
 rtl/c1_responder.sv | 190 +++++++++++++++++++
 tb/tb_c1_responder.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/c1_pkg.sv
// c1_pkg: shared definitions for the C1 bus responder.
//   - C1 command codes and the RESPONSE code driven back by the responder
//   - default parameter widths
//   - responder state enum
//   - alignment helper used when C1_PROTO_CHECK_EN is defined
package c1_pkg;

    localparam logic [2:0] CMD_NOP             = 3'd0;
    localparam logic [2:0] CMD_READ8           = 3'd1;
    localparam logic [2:0] CMD_READ16          = 3'd2;
    localparam logic [2:0] CMD_READ32          = 3'd3;
    localparam logic [2:0] CMD_INVALIDATE_LINE = 3'd4;
    localparam logic [2:0] CMD_WRITE8          = 3'd5;
    localparam logic [2:0] CMD_WRITE16         = 3'd6;
    localparam logic [2:0] CMD_WRITE32         = 3'd7;

    // Code the responder drives on C1 while returning a completion.
    localparam logic [2:0] C1_RESPONSE         = 3'd7;

    localparam int unsigned ADDR_W_DEF = 15;
    localparam int unsigned OFF_W_DEF  = 4;
    localparam int unsigned DATA_W_DEF = 16;

    typedef enum logic [2:0] {
        StIdle,
        StAddr2,
        StTurn,
        StReq,
        StWait,
        StResp1,
        StResp2
    } state_e;

    function automatic logic is_read(input logic [2:0] cmd);
        return (cmd == CMD_READ8) || (cmd == CMD_READ16) || (cmd == CMD_READ32);
    endfunction

    // Halfword accesses need offset[0]==0, word accesses offset[1:0]==0.
    function automatic logic misaligned(input logic [2:0] cmd, input logic [1:0] off_lo);
        logic bad;
        bad = 1'b0;
        if ((cmd == CMD_READ16) || (cmd == CMD_WRITE16)) begin
            bad = off_lo[0];
        end else if ((cmd == CMD_READ32) || (cmd == CMD_WRITE32)) begin
            bad = (off_lo != 2'b00);
        end
        return bad;
    endfunction

endpackage

// File: rtl/c1_responder.sv
// c1_responder: target-side responder for the multiplexed C1/A1/D1 bus.
// A command is captured over two bus cycles (tag+set, then offset), a turnaround
// cycle follows, the access is forwarded to the core as a single request, and the
// core completion is returned on C1/D1 as one RESPONSE cycle (two for READ32).
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   c1_in/c1_out/c1_oe            C1 command bus split (pad lives outside)
//   a1_in                         A1 address bus, initiator-driven
//   d1_in/d1_out/d1_oe            D1 data bus split
//   req_valid/req_cmd/req_addr/req_wdata, req_ready   core request handshake
//   resp_valid/resp_rdata         core completion pulse
//   proto_err                     (only with C1_PROTO_CHECK_EN) one-cycle error pulse
//
// Build option: define C1_PROTO_CHECK_EN to add alignment / command-consistency
// checking and the proto_err output. Erroneous transactions are not forwarded to
// the core and complete with zero read data.
//
// DATA_W is expected to be 16: a 32-bit core word is carried in two D1 beats.
module c1_responder
    import c1_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned OFF_W  = OFF_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2:0]              c1_in,
    output logic [2:0]              c1_out,
    output logic                    c1_oe,
    input  logic [ADDR_W-1:0]       a1_in,
    input  logic [DATA_W-1:0]       d1_in,
    output logic [DATA_W-1:0]       d1_out,
    output logic                    d1_oe,
    output logic                    req_valid,
    output logic [2:0]              req_cmd,
    output logic [ADDR_W+OFF_W-1:0] req_addr,
    output logic [31:0]             req_wdata,
    input  logic                    req_ready,
    input  logic                    resp_valid,
`ifdef C1_PROTO_CHECK_EN
    output logic                    proto_err,
`endif
    input  logic [31:0]             resp_rdata
);

    state_e            state_q, state_d;
    logic [2:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] tag_set_q, tag_set_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
`ifdef C1_PROTO_CHECK_EN
    logic              err_q, err_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cmd_q     <= '0;
            tag_set_q <= '0;
            off_q     <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
`ifdef C1_PROTO_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            tag_set_q <= tag_set_d;
            off_q     <= off_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
`ifdef C1_PROTO_CHECK_EN
            err_q     <= err_d;
`endif
        end
    end

    // Next-state and capture logic.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        tag_set_d = tag_set_q;
        off_d     = off_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
`ifdef C1_PROTO_CHECK_EN
        err_d     = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (c1_in != CMD_NOP) begin
                    cmd_d                = c1_in;
                    tag_set_d            = a1_in;
                    off_d                = '0;
                    wdata_d              = '0;
                    wdata_d[DATA_W-1:0]  = d1_in;
                    // Cleared here so an errored transaction returns zero data.
                    rdata_d              = '0;
`ifdef C1_PROTO_CHECK_EN
                    err_d                = 1'b0;
`endif
                    state_d              = StAddr2;
                end
            end
            StAddr2: begin
                off_d = a1_in[OFF_W-1:0];
                if (cmd_q == CMD_WRITE32) begin
                    wdata_d[2*DATA_W-1:DATA_W] = d1_in;
                end
`ifdef C1_PROTO_CHECK_EN
                err_d = misaligned(cmd_q, a1_in[1:0]) || (c1_in != cmd_q);
`endif
                state_d = StTurn;
            end
            StTurn: begin
`ifdef C1_PROTO_CHECK_EN
                state_d = err_q ? StResp1 : StReq;
`else
                state_d = StReq;
`endif
            end
            StReq: begin
                if (req_ready) begin
                    // A completion coincident with acceptance skips WAIT.
                    if (resp_valid) begin
                        rdata_d = resp_rdata;
                        state_d = StResp1;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (resp_valid) begin
                    rdata_d = resp_rdata;
                    state_d = StResp1;
                end
            end
            StResp1: begin
                state_d = (cmd_q == CMD_READ32) ? StResp2 : StIdle;
            end
            StResp2: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Bus and core outputs are decoded from state so reset drives them all low.
    always_comb begin
        c1_out    = '0;
        c1_oe     = 1'b0;
        d1_out    = '0;
        d1_oe     = 1'b0;
        req_valid = (state_q == StReq);
        unique case (state_q)
            StResp1: begin
                c1_oe  = 1'b1;
                c1_out = C1_RESPONSE;
                if (is_read(cmd_q)) begin
                    d1_oe  = 1'b1;
                    d1_out = rdata_q[DATA_W-1:0];
                end
            end
            StResp2: begin
                c1_oe  = 1'b1;
                c1_out = C1_RESPONSE;
                d1_oe  = 1'b1;
                d1_out = rdata_q[2*DATA_W-1:DATA_W];
            end
            default: begin
            end
        endcase
    end

    assign req_cmd   = cmd_q;
    assign req_addr  = {tag_set_q, off_q};
    assign req_wdata = wdata_q;

`ifdef C1_PROTO_CHECK_EN
    assign proto_err = (state_q == StTurn) && err_q;
`endif

endmodule

// File: tb/tb_c1_responder.sv
// Directed bench for c1_responder. Expected response beats are queued when a
// command is issued and popped as the DUT drives RESPONSE cycles.
// Define C1_PROTO_CHECK_EN to exercise the protocol-check build.
module tb_c1_responder;
    import c1_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  c1_in;
    logic [2:0]  c1_out;
    logic        c1_oe;
    logic [14:0] a1_in;
    logic [15:0] d1_in;
    logic [15:0] d1_out;
    logic        d1_oe;
    logic        req_valid;
    logic [2:0]  req_cmd;
    logic [18:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
`ifdef C1_PROTO_CHECK_EN
    logic        proto_err;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic        oe;
        logic [15:0] data;
    } beat_t;

    beat_t exp_q[$];

    always #5 clk = ~clk;

    c1_responder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .c1_in      (c1_in),
        .c1_out     (c1_out),
        .c1_oe      (c1_oe),
        .a1_in      (a1_in),
        .d1_in      (d1_in),
        .d1_out     (d1_out),
        .d1_oe      (d1_oe),
        .req_valid  (req_valid),
        .req_cmd    (req_cmd),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
`ifdef C1_PROTO_CHECK_EN
        .proto_err  (proto_err),
`endif
        .resp_rdata (resp_rdata)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One complete transaction. Entered and left at an IDLE sample point.
    // cmd2 is what the initiator shows on C1 during the offset cycle.
    // gap==0 returns the completion together with acceptance, else gap cycles later.
    task automatic txn(input string tag, input logic [2:0] cmd, input logic [2:0] cmd2,
                       input logic [14:0] ts, input logic [3:0] off,
                       input logic [15:0] dlo, input logic [15:0] dhi,
                       input int rdy_dly, input int gap, input logic [31:0] rdata,
                       input logic err_exp);
        logic [31:0] exp_rd;
        logic [31:0] exp_wd;
        beat_t       b;
        int          n;

        c1_in = cmd; a1_in = ts; d1_in = dlo;
        cyc();
        chk({tag, " addr2 oe"}, {62'b0, c1_oe, d1_oe}, 64'd0);
        c1_in = cmd2; a1_in = '0; a1_in[3:0] = off; d1_in = dhi;
        cyc();
        c1_in = CMD_NOP; a1_in = '0; d1_in = '0;
        chk({tag, " turn oe/req"}, {61'b0, c1_oe, d1_oe, req_valid}, 64'd0);
`ifdef C1_PROTO_CHECK_EN
        chk({tag, " turn proto_err"}, {63'b0, proto_err}, {63'b0, err_exp});
`endif

        exp_rd = err_exp ? 32'h0 : rdata;
        exp_wd = (cmd == CMD_WRITE32) ? {dhi, dlo} : {16'h0, dlo};
        if (is_read(cmd)) begin
            exp_q.push_back('{oe: 1'b1, data: exp_rd[15:0]});
            if (cmd == CMD_READ32) exp_q.push_back('{oe: 1'b1, data: exp_rd[31:16]});
        end else begin
            exp_q.push_back('{oe: 1'b0, data: 16'h0});
        end

        cyc();
        if (!err_exp) begin
            for (int i = 0; i < rdy_dly; i++) begin
                chk({tag, " req held"}, {31'b0, req_valid, req_wdata}, {31'b0, 1'b1, exp_wd});
                cyc();
            end
            chk({tag, " req_valid"}, {63'b0, req_valid}, 64'd1);
            chk({tag, " req_cmd"}, {61'b0, req_cmd}, {61'b0, cmd});
            chk({tag, " req_addr"}, {45'b0, req_addr}, {45'b0, ts, off});
            chk({tag, " req_wdata"}, {32'b0, req_wdata}, {32'b0, exp_wd});
            req_ready = 1'b1;
            if (gap == 0) begin
                resp_valid = 1'b1; resp_rdata = rdata;
            end
            cyc();
            req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = '0;
            if (gap != 0) begin
                chk({tag, " wait no req"}, {62'b0, req_valid, c1_oe}, 64'd0);
                for (int i = 1; i < gap; i++) cyc();
                resp_valid = 1'b1; resp_rdata = rdata;
                cyc();
                resp_valid = 1'b0; resp_rdata = '0;
            end
        end
        // First RESPONSE is due in the cycle right after completion (or after TURN).
        chk({tag, " resp latency"}, {63'b0, c1_oe}, 64'd1);
        n = 0;
        while (c1_oe && n < 4) begin
            chk({tag, " c1_out"}, {61'b0, c1_out}, {61'b0, C1_RESPONSE});
            chk({tag, " no req in resp"}, {63'b0, req_valid}, 64'd0);
            if (exp_q.size() == 0) begin
                chk({tag, " extra beat"}, 64'd1, 64'd0);
            end else begin
                b = exp_q.pop_front();
                chk({tag, " d1_oe"}, {63'b0, d1_oe}, {63'b0, b.oe});
                if (b.oe) chk({tag, " d1_out"}, {48'b0, d1_out}, {48'b0, b.data});
            end
            n++;
            cyc();
        end
        chk({tag, " oe released"}, {62'b0, c1_oe, d1_oe}, 64'd0);
        chk({tag, " beats left"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; c1_in = '0; a1_in = '0; d1_in = '0;
        req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = '0;
        cyc();
        cyc();
        chk("reset oe", {62'b0, c1_oe, d1_oe}, 64'd0);
        chk("reset req_valid", {63'b0, req_valid}, 64'd0);
        chk("reset buses", {29'b0, c1_out, d1_out, 16'b0}, 64'd0);
        chk("reset latches", {13'b0, req_cmd, req_addr, 29'b0}, 64'd0);
        chk("reset wdata", {32'b0, req_wdata}, 64'd0);
`ifdef C1_PROTO_CHECK_EN
        chk("reset proto_err", {63'b0, proto_err}, 64'd0);
`endif
        rst_n = 1'b1;
        cyc();

        txn("read8", CMD_READ8, CMD_READ8, 15'h0003, 4'h2, 16'h0, 16'h0,
            0, 0, 32'h0000_00A5, 1'b0);
        txn("read32", CMD_READ32, CMD_READ32, 15'h1234, 4'h4, 16'h0, 16'h0,
            0, 0, 32'hDEAD_BEEF, 1'b0);
        txn("write32", CMD_WRITE32, CMD_WRITE32, 15'h0040, 4'h0, 16'h5678, 16'h1234,
            3, 0, 32'h0, 1'b0);
        // Back-to-back: second command issued in the cycle the first's oe drops.
        txn("b2b read16", CMD_READ16, CMD_READ16, 15'h0777, 4'h6, 16'h0, 16'h0,
            1, 2, 32'h0000_1234, 1'b0);
        txn("b2b write8", CMD_WRITE8, CMD_WRITE8, 15'h7FFF, 4'hF, 16'h00C3, 16'hFFFF,
            0, 1, 32'h0, 1'b0);

        // Invalidate abandoned by reset while waiting for the core.
        c1_in = CMD_INVALIDATE_LINE; a1_in = 15'h0100; d1_in = '0;
        cyc();
        c1_in = CMD_INVALIDATE_LINE; a1_in = '0;
        cyc();
        c1_in = CMD_NOP;
        cyc();
        chk("inv req_valid", {63'b0, req_valid}, 64'd1);
        chk("inv req_addr", {45'b0, req_addr}, {45'b0, 15'h0100, 4'h0});
        req_ready = 1'b1;
        cyc();
        req_ready = 1'b0;
        chk("inv waiting", {62'b0, req_valid, c1_oe}, 64'd0);
        cyc();
        rst_n = 1'b0;
        #1;
        chk("inv reset oe", {61'b0, c1_oe, d1_oe, req_valid}, 64'd0);
        chk("inv reset latches", {45'b0, req_addr}, 64'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        resp_valid = 1'b1; resp_rdata = 32'hFFFF_FFFF;
        cyc();
        resp_valid = 1'b0; resp_rdata = '0;
        for (int i = 0; i < 4; i++) begin
            chk("inv stray resp", {62'b0, c1_oe, d1_oe}, 64'd0);
            cyc();
        end

`ifdef C1_PROTO_CHECK_EN
        txn("err read32 off2", CMD_READ32, CMD_READ32, 15'h0010, 4'h2, 16'h0, 16'h0,
            0, 0, 32'h0, 1'b1);
        txn("err cmd change", CMD_READ16, CMD_READ8, 15'h0020, 4'h4, 16'h0, 16'h0,
            0, 0, 32'h0, 1'b1);
        txn("ok after err", CMD_READ16, CMD_READ16, 15'h0021, 4'h2, 16'h0, 16'h0,
            0, 0, 32'h0000_4321, 1'b0);
`else
        // Without checking, a misaligned access is forwarded unchanged.
        txn("fwd read32 off2", CMD_READ32, CMD_READ32, 15'h0010, 4'h2, 16'h0, 16'h0,
            0, 0, 32'hCAFE_F00D, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
